// File: rtl/tdroplet_mux_ctrl.sv
// Two-branch droplet mux valve sequencer: round-robin grant, settle / dwell / flush timing,
// and an occupancy count for the downstream long-cell trap.
module tdroplet_mux_ctrl #(
  parameter int SETTLE_CYC = 2,
  parameter int DWELL_CYC  = 4,
  parameter int GUARD_CYC  = 3,
  parameter int CAPACITY   = 3,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [1:0]       req,
  input  logic             trap_clear,
  output logic             cp1,
  output logic             cp2,
  output logic [1:0]       ack,
  output logic             busy,
  output logic [CNT_W-1:0] trap_cnt,
  output logic             trap_full
);

  localparam int MAX_A   = (SETTLE_CYC > DWELL_CYC) ? SETTLE_CYC : DWELL_CYC;
  localparam int MAX_CYC = (MAX_A > GUARD_CYC) ? MAX_A : GUARD_CYC;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

  typedef enum logic [1:0] {IDLE, SETTLE, OPEN, FLUSH} state_t;

  state_t           state;
  logic [TW-1:0]    timer;
  logic             sel;
  logic             last_sel;
  logic             grant_ok;
  logic             grant_sel;
  logic             deliver;
  logic [CNT_W-1:0] cnt_next;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant_ok  = enable && !trap_full && (|req);
    grant_sel = (req == 2'b11) ? ~last_sel : req[1];
    deliver   = (state == OPEN) && (timer == '0);
    cnt_next  = trap_cnt;
    if (trap_clear)
      cnt_next = deliver ? CNT_W'(1) : '0;
    else if (deliver && trap_cnt != CAP)
      cnt_next = trap_cnt + 1'b1;
  end

  // Outputs are computed from the next state so the valves change on the same edge as the state.
  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      sel       <= 1'b0;
      last_sel  <= 1'b1;
      cp1       <= 1'b0;
      cp2       <= 1'b0;
      ack       <= '0;
      busy      <= 1'b0;
      trap_cnt  <= '0;
      trap_full <= 1'b0;
    end else begin
      ack       <= '0;
      trap_cnt  <= cnt_next;
      trap_full <= (cnt_next == CAP);
      case (state)
        IDLE: begin
          if (grant_ok) begin
            sel      <= grant_sel;
            last_sel <= grant_sel;
            timer    <= TW'(SETTLE_CYC - 1);
            state    <= SETTLE;
            busy     <= 1'b1;
          end
        end
        SETTLE: begin
          if (timer == '0) begin
            state <= OPEN;
            timer <= TW'(DWELL_CYC - 1);
            cp1   <= ~sel;
            cp2   <= sel;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        OPEN: begin
          if (timer == '0) begin
            state <= FLUSH;
            timer <= TW'(GUARD_CYC - 1);
            cp1   <= 1'b0;
            cp2   <= 1'b0;
            ack   <= sel ? 2'b10 : 2'b01;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        FLUSH: begin
          if (timer == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
